// File: rtl/cpu_io_responder.sv
// External-side endpoint of the CPU memory-mapped I/O port: DEPTH-entry output FIFO plus input holding register.
// Optional status word on CPUIn when IO_STATUS_EN is defined.
module cpu_io_responder #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic [31:0]   CPUOut,
    input  logic          OutStrobe,
    output logic [31:0]   CPUIn,
    input  logic          InTaken,
    output logic [31:0]   TxData,
    output logic          TxValid,
    input  logic          TxReady,
    input  logic [31:0]   RxData,
    input  logic          RxValid,
    output logic          RxReady,
    output logic          OutFull,
    output logic [CW-1:0] OutCount,
`ifdef IO_STATUS_EN
    input  logic          StatusSel,
`endif
    output logic          Overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;
    logic          push;
    logic          rx_full;
    logic [31:0]   hold;
    logic          take;
    logic          capture;

    assign TxValid = (OutCount != '0);
    assign OutFull = (OutCount == CW'(DEPTH));
    assign TxData  = TxValid ? mem[rd_ptr] : '0;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign pop  = TxValid & TxReady;
    assign push = OutStrobe & (~OutFull | pop);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            OutCount <= '0;
            Overflow <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= CPUOut;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   OutCount <= OutCount + CW'(1);
                2'b01:   OutCount <= OutCount - CW'(1);
                default: OutCount <= OutCount;
            endcase
            if (OutStrobe & ~push) begin
                Overflow <= 1'b1;
            end
        end
    end

`ifdef IO_STATUS_EN
    // A status read is not a data read, so it must not consume the held word.
    assign take = InTaken & ~StatusSel;
`else
    assign take = InTaken;
`endif

    assign RxReady = ~rx_full | take;
    assign capture = RxValid & RxReady;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            hold    <= '0;
            rx_full <= 1'b0;
        end else if (capture) begin
            hold    <= RxData;
            rx_full <= 1'b1;
        end else if (take) begin
            rx_full <= 1'b0;
        end
    end

`ifdef IO_STATUS_EN
    assign CPUIn = StatusSel ? {Overflow, 23'b0, rx_full, OutFull, 6'(OutCount)} : hold;
`else
    assign CPUIn = hold;
`endif

endmodule

// File: tb/tb_cpu_io_responder.sv
// Scoreboard bench for cpu_io_responder (DEPTH=4); status-word test runs when IO_STATUS_EN is defined.
module tb_cpu_io_responder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          Reset = 1'b1;
    logic [31:0]   CPUOut = '0;
    logic          OutStrobe = 1'b0;
    logic [31:0]   CPUIn;
    logic          InTaken = 1'b0;
    logic [31:0]   TxData;
    logic          TxValid;
    logic          TxReady = 1'b0;
    logic [31:0]   RxData = '0;
    logic          RxValid = 1'b0;
    logic          RxReady;
    logic          OutFull;
    logic [CW-1:0] OutCount;
    logic          Overflow;
`ifdef IO_STATUS_EN
    logic          StatusSel = 1'b0;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [31:0] sb[$];
    logic [31:0] rx_q[$];
    logic        m_ovf = 1'b0;

    cpu_io_responder #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .Reset(Reset), .CPUOut(CPUOut), .OutStrobe(OutStrobe),
        .CPUIn(CPUIn), .InTaken(InTaken), .TxData(TxData), .TxValid(TxValid),
        .TxReady(TxReady), .RxData(RxData), .RxValid(RxValid), .RxReady(RxReady),
        .OutFull(OutFull), .OutCount(OutCount),
`ifdef IO_STATUS_EN
        .StatusSel(StatusSel),
`endif
        .Overflow(Overflow)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    task automatic apply_reset();
        Reset = 1'b1;
        OutStrobe = 1'b0; TxReady = 1'b0; RxValid = 1'b0; InTaken = 1'b0;
        @(posedge CLK); #1;
        Reset = 1'b0;
        sb.delete(); rx_q.delete(); m_ovf = 1'b0;
    endtask

    // One FIFO cycle: drive, pop/compare the scoreboard head on a handshake, push accepted words.
    task automatic tx_cycle(input logic strobe, input logic [31:0] d, input logic ready);
        logic        p_pop, p_push;
        logic [31:0] exp;
        OutStrobe = strobe; CPUOut = d; TxReady = ready;
        #1;
        p_pop  = (sb.size() != 0) && ready;
        p_push = strobe && ((sb.size() != DEPTH) || p_pop);
        n_cmp++;
        if (TxValid !== (sb.size() != 0)) begin
            n_err++;
            $display("FAIL tx_valid: got %b expected %b", TxValid, sb.size() != 0);
        end
        if (p_pop) begin
            exp = sb.pop_front();
            n_cmp++;
            if (TxData !== exp) begin
                n_err++;
                $display("FAIL tx_pop: got %h expected %h", TxData, exp);
            end
        end
        if (p_push) sb.push_back(d);
        if (strobe && !p_push) m_ovf = 1'b1;
        @(posedge CLK); #1;
        OutStrobe = 1'b0; TxReady = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({TxValid, OutFull, Overflow, RxReady} !== 4'b0001 || TxData !== 32'h0 ||
            CPUIn !== 32'h0 || OutCount !== '0) begin
            n_err++;
            $display("FAIL reset: got v%b f%b o%b rr%b d%h in%h c%0d expected v0 f0 o0 rr1 d0 in0 c0",
                     TxValid, OutFull, Overflow, RxReady, TxData, CPUIn, OutCount);
        end
    endtask

    task automatic test_fifo_order();
        apply_reset();
        tx_cycle(1'b1, 32'h11, 1'b0);
        n_cmp++;
        if (TxData !== 32'h11 || TxValid !== 1'b1) begin
            n_err++;
            $display("FAIL fwft_latency: got %h/%b expected 00000011/1", TxData, TxValid);
        end
        tx_cycle(1'b1, 32'h22, 1'b0);
        tx_cycle(1'b1, 32'h33, 1'b0);
        tx_cycle(1'b0, 32'h0, 1'b0);
        n_cmp++;
        if (OutCount !== CW'(sb.size()) || TxData !== sb[0]) begin
            n_err++;
            $display("FAIL hold_stable: got c%0d d%h expected c%0d d%h", OutCount, TxData, sb.size(), sb[0]);
        end
        repeat (3) tx_cycle(1'b0, 32'h0, 1'b1);
        n_cmp++;
        if (TxValid !== 1'b0 || TxData !== 32'h0 || OutCount !== '0) begin
            n_err++;
            $display("FAIL drained: got v%b d%h c%0d expected v0 d0 c0", TxValid, TxData, OutCount);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] w;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            w = 32'hA0 + 32'(i);
            tx_cycle(1'b1, w, 1'b0);
            if (i == 3) begin
                n_cmp++;
                if (OutFull !== 1'b1 || Overflow !== 1'b0) begin
                    n_err++;
                    $display("FAIL full_at_4: got f%b o%b expected f1 o0", OutFull, Overflow);
                end
            end
        end
        n_cmp++;
        if (Overflow !== m_ovf || OutCount !== CW'(DEPTH)) begin
            n_err++;
            $display("FAIL overflow_set: got o%b c%0d expected o%b c%0d", Overflow, OutCount, m_ovf, DEPTH);
        end
        repeat (4) tx_cycle(1'b0, 32'h0, 1'b1);
        n_cmp++;
        if (Overflow !== 1'b1 || OutCount !== '0) begin
            n_err++;
            $display("FAIL overflow_sticky: got o%b c%0d expected o1 c0", Overflow, OutCount);
        end
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        for (int i = 1; i <= 4; i++) tx_cycle(1'b1, 32'hB0 + 32'(i), 1'b0);
        tx_cycle(1'b1, 32'hB5, 1'b1);
        n_cmp++;
        if (OutCount !== CW'(DEPTH) || OutFull !== 1'b1 || Overflow !== 1'b0 || TxData !== 32'hB2) begin
            n_err++;
            $display("FAIL full_push_pop: got c%0d f%b o%b d%h expected c4 f1 o0 d000000b2",
                     OutCount, OutFull, Overflow, TxData);
        end
        repeat (4) tx_cycle(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        tx_cycle(1'b1, 32'hC0, 1'b1);
        n_cmp++;
        if (OutCount !== CW'(1)) begin
            n_err++;
            $display("FAIL empty_strobe_push_only: got c%0d expected c1", OutCount);
        end
        for (int i = 1; i <= 6; i++) tx_cycle(1'b1, 32'hC0 + 32'(i), 1'b1);
        n_cmp++;
        if (OutCount !== CW'(1) || TxData !== 32'hC6) begin
            n_err++;
            $display("FAIL streaming: got c%0d d%h expected c1 d000000c6", OutCount, TxData);
        end
        tx_cycle(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_rx();
        logic [31:0] exp;
        apply_reset();
        RxValid = 1'b1; RxData = 32'hCAFE; #1;
        n_cmp++;
        if (RxReady !== 1'b1) begin
            n_err++; $display("FAIL rx_ready_empty: got %b expected 1", RxReady);
        end
        rx_q.push_back(RxData);
        @(posedge CLK); #1;
        RxData = 32'hBEEF; #1;
        exp = rx_q.pop_front();
        n_cmp++;
        if (CPUIn !== exp || RxReady !== 1'b0) begin
            n_err++; $display("FAIL rx_capture: got %h rr%b expected %h rr0", CPUIn, RxReady, exp);
        end
        @(posedge CLK); #1;
        n_cmp++;
        if (CPUIn !== exp) begin
            n_err++; $display("FAIL rx_held_off: got %h expected %h", CPUIn, exp);
        end
        InTaken = 1'b1; #1;
        n_cmp++;
        if (RxReady !== 1'b1) begin
            n_err++; $display("FAIL rx_ready_on_take: got %b expected 1", RxReady);
        end
        rx_q.push_back(RxData);
        @(posedge CLK); #1;
        InTaken = 1'b0; RxValid = 1'b0; #1;
        exp = rx_q.pop_front();
        n_cmp++;
        if (CPUIn !== exp || RxReady !== 1'b0) begin
            n_err++; $display("FAIL rx_take_and_load: got %h rr%b expected %h rr0", CPUIn, RxReady, exp);
        end
        for (int k = 0; k < 2; k++) begin
            InTaken = 1'b1;
            @(posedge CLK); #1;
            InTaken = 1'b0; #1;
            n_cmp++;
            if (RxReady !== 1'b1 || CPUIn !== exp) begin
                n_err++; $display("FAIL rx_take_%0d: got %h rr%b expected %h rr1", k, CPUIn, RxReady, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        RxValid = 1'b1; RxData = 32'h1234;
        @(posedge CLK); #1;
        RxValid = 1'b0;
        tx_cycle(1'b1, 32'hD1, 1'b0);
        tx_cycle(1'b1, 32'hD2, 1'b0);
        tx_cycle(1'b1, 32'hD3, 1'b0);
        tx_cycle(1'b0, 32'h0, 1'b1);
        n_cmp++;
        if (OutCount !== CW'(2) || RxReady !== 1'b0) begin
            n_err++; $display("FAIL pre_reset: got c%0d rr%b expected c2 rr0", OutCount, RxReady);
        end
        TxReady = 1'b1;
        #2 Reset = 1'b1;
        #1;
        n_cmp++;
        if ({TxValid, OutFull, Overflow, RxReady} !== 4'b0001 || TxData !== 32'h0 ||
            CPUIn !== 32'h0 || OutCount !== '0) begin
            n_err++;
            $display("FAIL async_reset: got v%b f%b o%b rr%b d%h in%h c%0d expected v0 f0 o0 rr1 d0 in0 c0",
                     TxValid, OutFull, Overflow, RxReady, TxData, CPUIn, OutCount);
        end
        apply_reset();
    endtask

`ifdef IO_STATUS_EN
    task automatic test_status();
        apply_reset();
        for (int i = 0; i < 5; i++) tx_cycle(1'b1, 32'hE0 + 32'(i), 1'b0);
        tx_cycle(1'b0, 32'h0, 1'b1);
        tx_cycle(1'b0, 32'h0, 1'b1);
        RxValid = 1'b1; RxData = 32'h5A5A;
        @(posedge CLK); #1;
        RxValid = 1'b0;
        StatusSel = 1'b1; InTaken = 1'b1; #1;
        n_cmp++;
        if (CPUIn !== 32'h8000_0082 || RxReady !== 1'b0) begin
            n_err++; $display("FAIL status_word: got %h rr%b expected 80000082 rr0", CPUIn, RxReady);
        end
        @(posedge CLK); #1;
        InTaken = 1'b0; StatusSel = 1'b0; #1;
        n_cmp++;
        if (CPUIn !== 32'h5A5A || RxReady !== 1'b0) begin
            n_err++; $display("FAIL status_no_take: got %h rr%b expected 00005a5a rr0", CPUIn, RxReady);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fifo_order();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_rx();
        test_async_reset();
`ifdef IO_STATUS_EN
        test_status();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
